// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the TX holding/FIFO side and the UART serializer.
// The master supplies a byte with tx_valid; the serializer answers with tx_ready
// when its single-entry holding register is empty.
interface uart_tx_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Byte source: drives data/valid, watches ready.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Serializer: consumes data/valid, reports ready.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer.
// Takes one byte at a time through a one-entry holding register and shifts out
// start bit, 7 or 8 data bits LSB first, optional parity and 1 or 2 stop bits.
// Every bit lasts exactly one xmit_pulse interval; all state changes happen
// only on cycles where xmit_pulse is high, and every output is registered so
// tx edges land one clk after the strobe.
module uart_tx_serializer (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        xmit_pulse,
  uart_tx_serializer_if.slave         tx_if,
  input  logic                        bit8,
  input  logic                        parity_en,
  input  logic                        odd_n_even,
  input  logic                        two_stop,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;

  // Holding register and its handshake flag.
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_ready_q, tx_ready_d;

  // Shift register and per-frame counters.
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;

  // Frame format captured when a byte leaves the holding register, so port
  // changes during a frame only affect the next one. Parity is resolved to the
  // final line value at that moment, which is why odd/even needs no latch.
  logic        cfg_bit8_q, cfg_bit8_d;
  logic        cfg_parity_en_q, cfg_parity_en_d;
  logic        cfg_two_stop_q, cfg_two_stop_d;
  logic        parity_bit_q, parity_bit_d;

  // Registered outputs.
  logic        tx_q, tx_d;
  logic        tx_busy_q, tx_busy_d;
  logic        tx_done_q, tx_done_d;

  // Decoded events shared by the next-state and datapath logic.
  logic        accept;
  logic [2:0]  last_data_idx;
  logic        data_last;
  logic        stop_last;
  logic        frame_end;
  logic        load;
  logic [7:0]  load_data;
  logic        load_parity;

  // Event decode: handshake, last data bit, last stop bit and shift-register load.
  always_comb begin
    accept        = tx_if.tx_valid & tx_ready_q;
    last_data_idx = cfg_bit8_q ? 3'd7 : 3'd6;
    data_last     = (bit_cnt_q == last_data_idx);
    stop_last     = (stop_cnt_q == cfg_two_stop_q);
    frame_end     = xmit_pulse & (state_q == STOP) & stop_last;
    load          = xmit_pulse & hold_full_q &
                    ((state_q == IDLE) | ((state_q == STOP) & stop_last));
    // Bit 7 is dropped in 7-bit mode so it can never reach the line or parity.
    load_data     = tx_if.tx_data & 8'h00 | hold_data_q & {bit8, 7'h7f};
    load_parity   = (^load_data) ^ odd_n_even;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the FSM only moves on an xmit_pulse.
  always_comb begin
    state_d = state_q;
    if (xmit_pulse) begin
      case (state_q)
        IDLE: begin
          if (hold_full_q) state_d = START;
        end
        START: begin
          state_d = DATA;
        end
        DATA: begin
          if (data_last) state_d = cfg_parity_en_q ? PARITY : STOP;
        end
        PARITY: begin
          state_d = STOP;
        end
        STOP: begin
          if (stop_last) state_d = hold_full_q ? START : IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Datapath and output logic: holding register, shift register, counters,
  // latched format and the next values of the registered outputs.
  always_comb begin
    hold_data_d     = hold_data_q;
    hold_full_d     = hold_full_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    stop_cnt_d      = stop_cnt_q;
    cfg_bit8_d      = cfg_bit8_q;
    cfg_parity_en_d = cfg_parity_en_q;
    cfg_two_stop_d  = cfg_two_stop_q;
    parity_bit_d    = parity_bit_q;
    tx_d            = tx_q;
    tx_done_d       = 1'b0;

    // A load empties the holding register; an accept can never coincide
    // with a load because accept needs tx_ready, i.e. an empty register.
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_data_d = tx_if.tx_data;
      hold_full_d = 1'b1;
    end

    if (load) begin
      shift_d         = load_data;
      cfg_bit8_d      = bit8;
      cfg_parity_en_d = parity_en;
      cfg_two_stop_d  = two_stop;
      parity_bit_d    = load_parity;
      tx_d            = 1'b0;
    end else if (xmit_pulse) begin
      case (state_q)
        START: begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          if (data_last) begin
            tx_d       = cfg_parity_en_q ? parity_bit_q : 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
        STOP: begin
          if (stop_last) begin
            tx_d = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_d = 1'b1;
        end
      endcase
    end

    if (frame_end) begin
      tx_done_d = 1'b1;
    end

    tx_ready_d = ~hold_full_d;
    tx_busy_d  = (state_d != IDLE);
  end

  // Datapath and output registers; reset abandons any partial frame at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data_q     <= 8'h00;
      hold_full_q     <= 1'b0;
      tx_ready_q      <= 1'b1;
      shift_q         <= 8'h00;
      bit_cnt_q       <= 3'd0;
      stop_cnt_q      <= 1'b0;
      cfg_bit8_q      <= 1'b1;
      cfg_parity_en_q <= 1'b0;
      cfg_two_stop_q  <= 1'b0;
      parity_bit_q    <= 1'b0;
      tx_q            <= 1'b1;
      tx_busy_q       <= 1'b0;
      tx_done_q       <= 1'b0;
    end else begin
      hold_data_q     <= hold_data_d;
      hold_full_q     <= hold_full_d;
      tx_ready_q      <= tx_ready_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      stop_cnt_q      <= stop_cnt_d;
      cfg_bit8_q      <= cfg_bit8_d;
      cfg_parity_en_q <= cfg_parity_en_d;
      cfg_two_stop_q  <= cfg_two_stop_d;
      parity_bit_q    <= parity_bit_d;
      tx_q            <= tx_d;
      tx_busy_q       <= tx_busy_d;
      tx_done_q       <= tx_done_d;
    end
  end

  assign tx_if.tx_ready = tx_ready_q;
  assign tx             = tx_q;
  assign tx_busy        = tx_busy_q;
  assign tx_done        = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer.
// A free-running strobe generator produces xmit_pulse every 16 clocks. Each
// accepted byte pushes its expected line bits onto a scoreboard queue; a
// monitor samples tx mid-period and at the end of every bit period while
// tx_busy is high and compares against the queue head.
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic xmit_pulse = 1'b0;
  logic bit8 = 1'b1;
  logic parity_en = 1'b0;
  logic odd_n_even = 1'b0;
  logic two_stop = 1'b0;
  logic tx;
  logic tx_busy;
  logic tx_done;

  uart_tx_serializer_if tx_if ();

  uart_tx_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .xmit_pulse (xmit_pulse),
    .tx_if      (tx_if.slave),
    .bit8       (bit8),
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
    .two_stop   (two_stop),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int done_count = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  bit exp_q[$];

  // Cycle counter used to measure frame lengths.
  always @(posedge clk) cyc++;

  // Strobe generator plus scoreboard check of tx in the middle and at the end of each bit period.
  always @(negedge clk) begin
    pulse_cnt = (pulse_cnt + 1) % 16;
    if (pulse_cnt == 7 || pulse_cnt == 15) begin
      assertions++;
      if (tx_busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_bit: tx=%b while busy, required no frame activity", tx);
        end else begin
          if (tx !== exp_q[0]) begin
            failures++;
            $display("[TB] FAIL frame_bit: tx=%b required %b (cyc %0d, remaining %0d)", tx, exp_q[0], cyc, exp_q.size());
          end
          if (pulse_cnt == 15) void'(exp_q.pop_front());
        end
      end else begin
        if (tx !== 1'b1) begin
          failures++;
          $display("[TB] FAIL idle_tx: tx=%b required 1 (cyc %0d)", tx, cyc);
        end
      end
    end
    xmit_pulse = (pulse_cnt == 15);
  end

  // Busy-rise and done-pulse tracking, with a one-cycle width check on tx_done.
  always @(negedge clk) begin
    if (tx_busy === 1'b1 && prev_busy !== 1'b1) start_cyc = cyc;
    if (tx_done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
      assertions++;
      if (prev_done === 1'b1) begin
        failures++;
        $display("[TB] FAIL done_width: tx_done high on consecutive cycles, required single-cycle pulse");
      end
    end
    prev_busy = tx_busy;
    prev_done = tx_done;
  end

  // Expected line bits for one frame: start, data LSB first, parity, stop bits.
  task automatic push_frame(input logic [7:0] d, input bit b8, input bit pe, input bit odd, input bit two);
    int n;
    bit p;
    n = b8 ? 8 : 7;
    p = odd;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) exp_q.push_back(p);
    exp_q.push_back(1'b1);
    if (two) exp_q.push_back(1'b1);
  endtask

  // Offer a byte and hold tx_valid until the serializer takes it.
  task automatic send_byte(input logic [7:0] d);
    int k;
    bit ok;
    k = 0;
    ok = 0;
    @(negedge clk);
    tx_if.tx_data = d;
    tx_if.tx_valid = 1'b1;
    while (!ok && k < 1000) begin
      if (tx_if.tx_ready === 1'b1) ok = 1;
      @(negedge clk);
      k++;
    end
    tx_if.tx_valid = 1'b0;
    assertions++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL accept: byte %h not accepted, tx_ready=%b, required acceptance within 1000 cycles", d, tx_if.tx_ready);
    end
  endtask

  task automatic wait_busy(input int bound);
    int k;
    k = 0;
    while (tx_busy !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    assertions++;
    if (tx_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_start: tx_busy=%b required 1 within %0d cycles", tx_busy, bound);
    end
  endtask

  task automatic wait_done(input int target, input int bound);
    int k;
    k = 0;
    while ((done_count < target || exp_q.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    assertions++;
    if (done_count < target || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL frame_complete: done_count=%0d pending_bits=%0d, required done_count=%0d pending_bits=0", done_count, exp_q.size(), target);
    end
  endtask

  task automatic check_length(input string name, input int required);
    assertions++;
    if (done_cyc - start_cyc != required) begin
      failures++;
      $display("[TB] FAIL %s: busy-to-done %0d cycles, required %0d", name, done_cyc - start_cyc, required);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    assertions += 4;
    if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: %b required 1", tx); end
    if (tx_if.tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: %b required 1", tx_if.tx_ready); end
    if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: %b required 0", tx_busy); end
    if (tx_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: %b required 0", tx_done); end
    reset = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_8n1();
    int base;
    $display("[TB] 8N1 frame of 0x55");
    bit8 = 1; parity_en = 0; odd_n_even = 0; two_stop = 0;
    base = done_count;
    send_byte(8'h55);
    push_frame(8'h55, 1, 0, 0, 0);
    wait_done(base + 1, 400);
    check_length("len_8n1", 160);
    repeat (40) @(negedge clk);
  endtask

  task automatic test_7e2();
    int base;
    $display("[TB] 7E2 frame of 0xA3");
    bit8 = 0; parity_en = 1; odd_n_even = 0; two_stop = 1;
    base = done_count;
    send_byte(8'hA3);
    push_frame(8'hA3, 0, 1, 0, 1);
    wait_done(base + 1, 400);
    check_length("len_7e2", 176);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_8o1();
    logic [7:0] vals [3];
    int base;
    $display("[TB] 8O1 frames");
    vals[0] = 8'hFF; vals[1] = 8'h00; vals[2] = 8'h01;
    bit8 = 1; parity_en = 1; odd_n_even = 1; two_stop = 0;
    for (int i = 0; i < 3; i++) begin
      base = done_count;
      send_byte(vals[i]);
      push_frame(vals[i], 1, 1, 1, 0);
      wait_done(base + 1, 400);
      check_length("len_8o1", 176);
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ready_seen;
    $display("[TB] back-to-back 0x11 0x22 0x33");
    bit8 = 1; parity_en = 0; odd_n_even = 0; two_stop = 0;
    base = done_count;
    send_byte(8'h11);
    push_frame(8'h11, 1, 0, 0, 0);
    send_byte(8'h22);
    push_frame(8'h22, 1, 0, 0, 0);
    ready_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_if.tx_ready !== 1'b0) ready_seen = 1;
    end
    assertions++;
    if (ready_seen) begin
      failures++;
      $display("[TB] FAIL ready_while_full: tx_ready rose while holding register full, required 0");
    end
    send_byte(8'h33);
    push_frame(8'h33, 1, 0, 0, 0);
    wait_done(base + 3, 800);
    check_length("len_back_to_back", 480);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_config_change();
    int base;
    $display("[TB] config change during DATA");
    bit8 = 1; parity_en = 0; odd_n_even = 0; two_stop = 0;
    base = done_count;
    send_byte(8'h3C);
    push_frame(8'h3C, 1, 0, 0, 0);
    wait_busy(100);
    repeat (3 * 16) @(negedge clk);
    parity_en = 1; two_stop = 1;
    send_byte(8'h96);
    push_frame(8'h96, 1, 1, 0, 1);
    wait_done(base + 2, 800);
    check_length("len_config_change", 352);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int dc;
    $display("[TB] reset during data bit 3");
    bit8 = 1; parity_en = 0; odd_n_even = 0; two_stop = 0;
    send_byte(8'h33);
    push_frame(8'h33, 1, 0, 0, 0);
    wait_busy(100);
    repeat (4 * 16 + 3) @(negedge clk);
    dc = done_count;
    reset = 1'b1;
    #1;
    assertions += 4;
    if (tx !== 1'b1) begin failures++; $display("[TB] FAIL midreset_tx: %b required 1", tx); end
    if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: %b required 0", tx_busy); end
    if (tx_if.tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready: %b required 1", tx_if.tx_ready); end
    if (tx_done !== 1'b0) begin failures++; $display("[TB] FAIL midreset_done: %b required 0", tx_done); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    assertions++;
    if (done_count != dc) begin
      failures++;
      $display("[TB] FAIL midreset_no_done: done_count=%0d required %0d", done_count, dc);
    end
    send_byte(8'h5A);
    push_frame(8'h5A, 1, 0, 0, 0);
    wait_done(dc + 1, 400);
    check_length("len_after_reset", 160);
    repeat (20) @(negedge clk);
  endtask

  // Main sequence.
  initial begin
    tx_if.tx_data = 8'h00;
    tx_if.tx_valid = 1'b0;
    test_reset();
    test_8n1();
    test_7e2();
    test_8o1();
    test_back_to_back();
    test_config_change();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit serializer for the CoreUARTapb datapath. Accepts one byte at a time from the TX holding/FIFO side via a valid/ready handshake and shifts out a framed serial character on `tx`. Frame format is start bit, 7 or 8 data bits LSB first, optional parity, then 1 or 2 stop bits. Each bit period is exactly one interval between `xmit_pulse` strobes from the baud clock generator, which sits directly upstream.

## Interface
- No parameters. Frame format is selected by ports.
- `clk` in 1: system clock; all logic is synchronous to its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `xmit_pulse` in 1: single-`clk`-cycle strobe, once per bit period; comes from the baud clock generator.
- `tx_data` in 8: byte to send. Bit 7 is ignored when `bit8`=0.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: one-entry holding register is empty; transfer occurs when `tx_valid & tx_ready`.
- `bit8` in 1: 1 = 8 data bits, 0 = 7 data bits.
- `parity_en` in 1: insert a parity bit.
- `odd_n_even` in 1: 1 = odd parity, 0 = even parity.
- `two_stop` in 1: 1 = two stop bits, 0 = one stop bit.
- `tx` out 1: serial output; idles high.
- `tx_busy` out 1: a frame is in progress (state ≠ IDLE).
- `tx_done` out 1: one-cycle pulse in the cycle after the last stop bit period ends.

## Operation
- **Holding register (1 entry).**
  - On `tx_valid & tx_ready`, capture `tx_data` and set `hold_full`.
  - `tx_ready` = !`hold_full`, registered.
- **Config latch.** `bit8`, `parity_en`, `odd_n_even` and `two_stop` are latched when a byte moves from the holding register into the shift register. Changes mid-frame do not affect the current frame.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. All transitions occur only in cycles where `xmit_pulse`=1.
  - **IDLE:** if `hold_full`, go to START. Load the shift register from the holding register, clear `hold_full`, latch config, and set `tx`=0.
  - **START → DATA:** `tx` = shift[0]; bit counter = 0.
  - **DATA:** shift right. `tx` = next bit. After the last data bit (count 6 or 7), go to PARITY if parity is enabled, else go to STOP with `tx`=1.
  - **PARITY:** `tx` = parity. Even parity = XOR of the sent data bits (7 or 8). Odd parity = its inverse. Next state is STOP with `tx`=1.
  - **STOP:** lasts 1 or 2 bit periods (stop counter). At the end of the final stop period:
    - pulse `tx_done`;
    - if `hold_full`, go directly to START (back-to-back, no idle gap) with a load identical to the IDLE case;
    - else go to IDLE with `tx`=1.
- Parity is computed on the latched data and is never affected by bit 7 in 7-bit mode.
- **Simultaneous events.**
  - If a load from the holding register and a `tx_valid` arrive in the same cycle, the new byte is not accepted because `tx_ready` was 0. `tx_ready` rises the next cycle.
  - `xmit_pulse` while IDLE and empty has no effect.
- **Reset, including mid-frame.** Immediately:
  - FSM → IDLE, holding register cleared;
  - `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0;
  - the partial frame is abandoned, with no stop bit completed.

## Timing
- **Output registers.** `tx`, `tx_ready`, `tx_busy` and `tx_done` are all registered.
- **Start latency.** The start bit begins one `clk` after the first `xmit_pulse` that sees `hold_full`=1. Worst case from acceptance is one bit period plus 1 cycle.
- **Bit period.** Each bit is held for exactly one `xmit_pulse` interval; edges on `tx` occur 1 `clk` after `xmit_pulse`.
- **Frame length** in bit periods = 1 + (7|8) + `parity_en` + (1|2). Range is 9..12.
- **`tx_done`.** Asserted for 1 cycle, coincident with the `tx` update that ends the last stop bit.
- **`tx_busy`.** High from the start-bit edge until that same edge.
- **Throughput.** The holding register refills during the frame, so continuous data yields gap-free frames.

## Test plan
- **8N1.** Reset, then `tx_data`=0x55, `bit8`=1, no parity, 1 stop, `xmit_pulse` every 16 clocks. Required: `tx` = 0,1,0,1,0,1,0,1,0,1 each held 16 clocks, `tx_done` pulse, then idle high. Total 160 clocks of frame.
- **7E2.** `tx_data`=0xA3, `bit8`=0, even parity, 2 stop. Required: `tx` = 0, 1,1,0,0,0,1,0, parity 1, then 1,1. Bit 7 is ignored, so 11 periods total.
- **8O1.** `tx_data`=0xFF, odd parity. Required: parity bit = 1. With `tx_data`=0x00: parity bit = 1. With 0x01: parity bit = 0.
- **Back-to-back.** Assert `tx_valid` with 0x11, then 0x22 as soon as `tx_ready` rises. Required: the second start bit immediately follows the first stop bit with no idle period; `tx_ready` stays 0 while the holding register is full; 3 bytes take exactly 30 bit periods.
- **Mid-frame config change.** Toggle `parity_en` and `two_stop` during the DATA state. Required: the current frame keeps its latched format; the next frame uses the new one.
- **Reset mid-frame.** Assert `reset` during data bit 3. Required, same cycle: `tx`=1, `tx_busy`=0, `tx_ready`=1, no `tx_done`. After release, a new 0x5A frame is sent correctly.
